rr_mux_nx1: RTL and testbench

RR_MUX_NX1 -- requirements
Module: rr_mux_nx1

---
 rtl/rr_mux_nx1.sv | 96 +++++++++
 tb/tb_rr_mux_nx1.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_nx1.sv
// N-to-1 multiplexer with a fixed-select or round-robin arbiter feeding a
// one-entry registered output stage with valid/ready handshakes.
module rr_mux_nx1 #(
    parameter int  N_CH  = 4,
    parameter int  WIDTH = 8,
    localparam int SELW  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic            load_ok_s;
    logic            sel_hit_s;
    logic            hi_found_s;
    logic            lo_found_s;
    logic [SELW-1:0] hi_idx_s;
    logic [SELW-1:0] lo_idx_s;
    logic            grant_s;
    logic [SELW-1:0] grant_idx_s;
    logic [SELW-1:0] next_ptr_s;
    logic [WIDTH-1:0] grant_data_s;
    logic [SELW-1:0] rr_ptr_r;

    // Arbitration: the descending scan leaves the lowest valid index at or
    // above rr_ptr in hi_*, and the lowest valid index overall (the wrap
    // candidate) in lo_*.
    always_comb begin
        load_ok_s   = !out_valid || out_ready;
        sel_hit_s   = 1'b0;
        hi_found_s  = 1'b0;
        lo_found_s  = 1'b0;
        hi_idx_s    = '0;
        lo_idx_s    = '0;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            sel_hit_s  = sel_hit_s || (in_valid[i] && (sel == SELW'(i)));
            lo_found_s = lo_found_s || in_valid[i];
            lo_idx_s   = in_valid[i] ? SELW'(i) : lo_idx_s;
            hi_found_s = hi_found_s || (in_valid[i] && (SELW'(i) >= rr_ptr_r));
            hi_idx_s   = (in_valid[i] && (SELW'(i) >= rr_ptr_r)) ? SELW'(i) : hi_idx_s;
        end
        if (rst || !load_ok_s) begin
            grant_s     = 1'b0;
            grant_idx_s = '0;
        end else if (!mode) begin
            grant_s     = sel_hit_s;
            grant_idx_s = sel;
        end else begin
            grant_s     = hi_found_s || lo_found_s;
            grant_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
        end
    end

    // One-hot ready and the granted channel's data
    always_comb begin
        in_ready     = '0;
        grant_data_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i]  = grant_s && (grant_idx_s == SELW'(i));
            grant_data_s = (grant_s && (grant_idx_s == SELW'(i)))
                           ? in_data[i*WIDTH +: WIDTH] : grant_data_s;
        end
        next_ptr_s = (grant_idx_s == SELW'(N_CH - 1)) ? '0 : (grant_idx_s + SELW'(1));
    end

    // Output register and round-robin pointer; a grant always wins over a
    // plain drain so a register being emptied refills in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr_r  <= '0;
        end else if (grant_s) begin
            out_valid <= 1'b1;
            out_data  <= grant_data_s;
            out_ch    <= grant_idx_s;
            if (mode) begin
                rr_ptr_r <= next_ptr_s;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Scoreboard bench for rr_mux_nx1: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_rr_mux_nx1;
    localparam int NCH = 4;
    localparam int W   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic             mode;
    logic [1:0]       sel;
    logic [W-1:0]     out_data;
    logic [1:0]       out_ch;
    logic             out_valid;
    logic             out_ready;

    logic [23:0] d3_in_data;
    logic [2:0]  d3_in_valid;
    logic [2:0]  d3_in_ready;
    logic        d3_mode;
    logic [1:0]  d3_sel;
    logic [7:0]  d3_out_data;
    logic [1:0]  d3_out_ch;
    logic        d3_out_valid;
    logic        d3_out_ready;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb[$];
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    rr_mux_nx1 #(.N_CH(NCH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_nx1 #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
        .out_ch(d3_out_ch), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the grant from the rules and
    // queues whatever the DUT should emit next.
    task automatic cycle(input logic r, input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic rdy, input logic [31:0] d);
        bit         g;
        int         gi;
        logic [3:0] exp_rdy;
        @(posedge clk);
        #1;
        rst = r; mode = m; sel = s; in_valid = v; out_ready = rdy; in_data = d;
        #3;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_ch", out_ch, m_ch);
        end
        g  = 1'b0;
        gi = 0;
        if (!r && (!m_valid || rdy)) begin
            if (!m) begin
                if (int'(s) < NCH && v[s]) begin
                    g  = 1'b1;
                    gi = int'(s);
                end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    int idx = (m_ptr + k) % NCH;
                    if (!g && v[idx]) begin
                        g  = 1'b1;
                        gi = idx;
                    end
                end
            end
        end
        exp_rdy = g ? (4'b0001 << gi) : 4'b0000;
        chk("in_ready", in_ready, exp_rdy);
        if (r) begin
            m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
            sb.delete();
        end else if (g) begin
            m_valid = 1'b1;
            m_data  = d[gi*8 +: 8];
            m_ch    = gi;
            sb.push_back({m_data, 2'(gi)});
            if (m) m_ptr = (gi + 1) % NCH;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: every output handshake must match the oldest queued entry
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", out_data, e[9:2]);
                    chk("sb_ch", out_ch, e[1:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; out_ready = 1'b0; in_data = '0;
        d3_in_data = '0; d3_in_valid = 3'b000; d3_mode = 1'b0; d3_sel = 2'd0; d3_out_ready = 1'b0;
        m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
        repeat (2) @(posedge clk);

        cycle(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 32'h55555555);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_in_ready", in_ready, 4'b0000);

        cycle(1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 32'hA3A2A1A0);
        chk("fix_sel2_ready", in_ready, 4'b0100);

        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 32'hA3A2A1A0);
            if (k == 0) begin
                chk("fix_out_data", out_data, 8'hA2);
                chk("fix_out_ch", out_ch, 2'd2);
            end else begin
                chk("rr_seq_ch", out_ch, (k - 1) % 4);
            end
            chk("rr_seq_ready", in_ready, 4'b0001 << (k % 4));
        end

        cycle(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 32'h13121110);
        chk("rr_skip_ready", in_ready, 4'b1000);
        chk("rr_skip_prev_ch", out_ch, 2'd1);
        cycle(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 32'h23222120);
        chk("rr_wrap_ready", in_ready, 4'b0010);
        chk("rr_wrap_ch", out_ch, 2'd3);
        chk("rr_wrap_data", out_data, 8'h13);

        cycle(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, 32'h0);
        chk("hold_ch", out_ch, 2'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(1, 15)), 1'b0, $urandom);
            chk("stall_ready", in_ready, 4'b0000);
            chk("stall_data", out_data, 8'h21);
            chk("stall_ch", out_ch, 2'd1);
        end
        cycle(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 32'h43424140);
        chk("refill_ready", in_ready, 4'b0100);
        chk("refill_drain_ch", out_ch, 2'd1);
        cycle(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, 32'h0);
        chk("refill_ch", out_ch, 2'd2);
        chk("refill_data", out_data, 8'h42);

        cycle(1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 32'hFFFFFFFF);
        chk("rst_stall_ready", in_ready, 4'b0000);
        cycle(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 32'h33323130);
        chk("rst_clr_valid", out_valid, 1'b0);
        chk("rst_clr_data", out_data, 8'h00);
        chk("rst_clr_ch", out_ch, 2'd0);
        chk("rst_first_grant", in_ready, 4'b0001);

        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), $urandom);
        end
        repeat (3) cycle(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 32'h0);
        chk("sb_drained", sb.size(), 0);

        d3_in_data = 24'h3C2B1A; d3_in_valid = 3'b111; d3_mode = 1'b0;
        d3_sel = 2'd3; d3_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #4;
            chk("n3_sel3_ready", d3_in_ready, 3'b000);
            chk("n3_sel3_valid", d3_out_valid, 1'b0);
        end
        d3_sel = 2'd2;
        #1;
        chk("n3_sel2_ready", d3_in_ready, 3'b100);
        @(posedge clk);
        #4;
        chk("n3_sel2_valid", d3_out_valid, 1'b1);
        chk("n3_sel2_ch", d3_out_ch, 2'd2);
        chk("n3_sel2_data", d3_out_data, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
